// File: rtl/cache_wb_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_wb_reader_pkg
// Description : Shared definitions for the cache write-back reader: data and
//               bank geometry, beat counter width and FSM state encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cache_wb_reader_pkg;

  localparam int c_DATA_WIDTH   = 32;
  localparam int c_BANK_NUM     = 4;
  localparam int c_RAM_NUM      = c_BANK_NUM;
  localparam int c_CACHE_RAM_AW = 10;
  localparam int c_WB_BEAT_W    = 2;

  // Write-back FSM states
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_RD   = 2'd1,
    WB_CAP  = 2'd2,
    WB_SEND = 2'd3
  } wb_state_e;

endpackage : cache_wb_reader_pkg
`default_nettype wire

// File: rtl/cache_wb_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_wb_reader_if
// Description : Bundle of the request, bank-read and write-back beat signals
//               of the cache write-back reader.
//               slave  modport : the reader itself
//               master modport : controller / bank array / bus side
// Ports       : none (signals only)
//   req_valid_i/req_ready_o/req_index_i/req_tag_i : victim-line request
//   bank_rd_addr_o/bank_rd_data_i                 : bank read port
//   wb_valid_o/wb_ready_i/wb_data_o/wb_addr_o/wb_last_o : beat channel
//   busy_o                                        : reader not idle
//   wb_parity_o (only with WB_PARITY_EN)          : even parity of wb_data_o
// Config      : `WB_PARITY_EN adds wb_parity_o
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_wb_reader_if
  import cache_wb_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = c_DATA_WIDTH,
  parameter int BANK_NUM     = c_BANK_NUM,
  parameter int CACHE_RAM_AW = c_CACHE_RAM_AW,
  parameter int IDX_W        = CACHE_RAM_AW - 2,
  parameter int TAG_W        = 32 - IDX_W - 4
);

  logic                           req_valid_i;
  logic                           req_ready_o;
  logic [IDX_W-1:0]               req_index_i;
  logic [TAG_W-1:0]               req_tag_i;
  logic [CACHE_RAM_AW-1:0]        bank_rd_addr_o;
  logic [BANK_NUM*DATA_WIDTH-1:0] bank_rd_data_i;
  logic                           wb_valid_o;
  logic                           wb_ready_i;
  logic [DATA_WIDTH-1:0]          wb_data_o;
  logic [31:0]                    wb_addr_o;
  logic                           wb_last_o;
  logic                           busy_o;
`ifdef WB_PARITY_EN
  logic                           wb_parity_o;
`endif

  modport slave (
    input  req_valid_i, req_index_i, req_tag_i, bank_rd_data_i, wb_ready_i,
    output req_ready_o, bank_rd_addr_o, wb_valid_o, wb_data_o, wb_addr_o,
           wb_last_o, busy_o
`ifdef WB_PARITY_EN
    , output wb_parity_o
`endif
  );

  modport master (
    output req_valid_i, req_index_i, req_tag_i, bank_rd_data_i, wb_ready_i,
    input  req_ready_o, bank_rd_addr_o, wb_valid_o, wb_data_o, wb_addr_o,
           wb_last_o, busy_o
`ifdef WB_PARITY_EN
    , input wb_parity_o
`endif
  );

endinterface : cache_wb_reader_if
`default_nettype wire

// File: rtl/cache_wb_reader_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_line_buffer
// Description : Holds one captured cache line (BANK_NUM words) and presents
//               the word selected by the current beat index.
// Ports       : clk, rst_n         - clock, async active-low reset
//               i_load             - capture i_line at the clock edge
//               i_line             - full line, word k on [DW*k +: DW]
//               i_sel              - beat index selecting the output word
//               o_word             - selected word
//               o_parity           - even parity of o_word (WB_PARITY_EN)
// Config      : `WB_PARITY_EN adds o_parity
// Revision    : 1.0 - initial release
// ============================================================================
module wb_line_buffer
  import cache_wb_reader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int BANK_NUM   = c_BANK_NUM,
  parameter int BEAT_W     = c_WB_BEAT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_load,
  input  logic [BANK_NUM*DATA_WIDTH-1:0] i_line,
  input  logic [BEAT_W-1:0]              i_sel,
  output logic [DATA_WIDTH-1:0]          o_word
`ifdef WB_PARITY_EN
  , output logic                         o_parity
`endif
);

  logic [DATA_WIDTH-1:0] r_words [BANK_NUM];
`ifdef WB_PARITY_EN
  logic [BANK_NUM-1:0]   r_par;
`endif

  generate
    for (genvar k = 0; k < BANK_NUM; k++) begin : g_word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_words[k] <= '0;
        end else if (i_load) begin
          r_words[k] <= i_line[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end

`ifdef WB_PARITY_EN
      // Parity is computed at capture so it leaves a flop alongside the word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_par[k] <= 1'b0;
        end else if (i_load) begin
          r_par[k] <= ^i_line[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`endif
    end
  endgenerate

  assign o_word = r_words[i_sel];
`ifdef WB_PARITY_EN
  assign o_parity = r_par[i_sel];
`endif

endmodule : wb_line_buffer
`default_nettype wire

// File: rtl/cache_wb_reader.sv
`default_nettype none
// ============================================================================
// Module      : cache_wb_reader
// Description : Data-cache write-back reader. On a victim request it reads
//               one full line from the bank array (all banks in parallel),
//               captures it, and streams it as BANK_NUM beats over a
//               valid/ready channel with addresses {tag, index, beat, 2'b00}.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset
//               bus   - cache_wb_reader_if.slave (request, bank read port,
//                       beat channel, busy; parity with WB_PARITY_EN)
// Config      : `WB_PARITY_EN adds bus.wb_parity_o
// Revision    : 1.0 - initial release
// ============================================================================
module cache_wb_reader
  import cache_wb_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = c_DATA_WIDTH,
  parameter int BANK_NUM     = c_RAM_NUM,
  parameter int CACHE_RAM_AW = c_CACHE_RAM_AW,
  parameter int IDX_W        = CACHE_RAM_AW - 2,
  parameter int TAG_W        = 32 - IDX_W - 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_wb_reader_if.slave  bus
);

  localparam int              BEAT_W      = c_WB_BEAT_W;
  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BANK_NUM - 1);

  wb_state_e               r_state;
  logic [TAG_W-1:0]        r_tag;
  logic [IDX_W-1:0]        r_index;
  logic [CACHE_RAM_AW-1:0] r_bank_addr;
  logic [BEAT_W-1:0]       r_beat;
  logic                    r_req_ready;
  logic                    r_busy;
  logic                    r_wb_valid;
  logic                    r_wb_last;

  logic                    w_req_fire;
  logic                    w_beat_fire;
  logic                    w_load;
  logic [DATA_WIDTH-1:0]   w_word;

  // r_req_ready is only set in IDLE, so it doubles as the state qualifier.
  assign w_req_fire  = bus.req_valid_i && r_req_ready;
  assign w_beat_fire = r_wb_valid && bus.wb_ready_i;
  // Bank data is valid during CAP (address sampled at the end of RD).
  assign w_load      = (r_state == WB_CAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WB_IDLE;
      r_tag       <= '0;
      r_index     <= '0;
      r_bank_addr <= '0;
      r_beat      <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_last   <= 1'b0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (w_req_fire) begin
            r_tag       <= bus.req_tag_i;
            r_index     <= bus.req_index_i;
            r_bank_addr <= {bus.req_index_i, 2'b00};
            r_beat      <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= WB_RD;
          end
        end
        WB_RD: begin
          r_state <= WB_CAP;
        end
        WB_CAP: begin
          r_wb_valid <= 1'b1;
          r_wb_last  <= 1'b0;
          r_state    <= WB_SEND;
        end
        WB_SEND: begin
          if (w_beat_fire) begin
            if (r_beat == c_LAST_BEAT) begin
              // Beat counter stays at the last beat until the next accept.
              r_wb_valid  <= 1'b0;
              r_wb_last   <= 1'b0;
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= WB_IDLE;
            end else begin
              r_beat    <= r_beat + 1'b1;
              r_wb_last <= (r_beat == (c_LAST_BEAT - 1'b1));
            end
          end
        end
        default: begin
          r_state <= WB_IDLE;
        end
      endcase
    end
  end

  wb_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BANK_NUM   (BANK_NUM),
    .BEAT_W     (BEAT_W)
  ) u_line_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_line   (bus.bank_rd_data_i),
    .i_sel    (r_beat),
    .o_word   (w_word)
`ifdef WB_PARITY_EN
    , .o_parity (bus.wb_parity_o)
`endif
  );

  assign bus.req_ready_o    = r_req_ready;
  assign bus.busy_o         = r_busy;
  assign bus.bank_rd_addr_o = r_bank_addr;
  assign bus.wb_valid_o     = r_wb_valid;
  assign bus.wb_last_o      = r_wb_last;
  assign bus.wb_data_o      = w_word;
  assign bus.wb_addr_o      = {r_tag, r_index, r_beat, 2'b00};

endmodule : cache_wb_reader
`default_nettype wire

// File: tb/tb_cache_wb_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_wb_reader
// Description : Self-checking bench for cache_wb_reader. A bank-array model
//               answers reads one cycle after the address; expected beats
//               are queued when a request is driven and compared as the DUT
//               hands beats over.
// Config      : `WB_PARITY_EN also checks wb_parity_o
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_wb_reader;
  import cache_wb_reader_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        last;
    int          beat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  exp_t         sb[$];
  exp_t         e;
  logic [127:0] mem [256];
  int           first_cyc;
  int           last_cyc;
  int           hs_count = 0;
  logic [31:0]  last_addr;
  logic         stall_prev = 1'b0;
  logic [31:0]  held_data;
  logic [31:0]  held_addr;
  logic         held_last;
  int           c0;
  int           c1;
  int           hs_base;

  cache_wb_reader_if bif ();

  cache_wb_reader u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank array: synchronous read, all banks share the line address.
  always @(posedge clk) bif.bank_rd_data_i <= mem[bif.bank_rd_addr_o[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [127:0] make_line(input int i);
    logic [127:0] l;
    for (int k = 0; k < 4; k++)
      l[32*k +: 32] = {8'(i), 8'(8'hA0 + k), 16'(i * 37 + k * 11)};
    return l;
  endfunction

  task automatic push_line(input logic [7:0] idx, input logic [19:0] tag);
    exp_t x;
    logic [127:0] l;
    l = mem[idx];
    for (int k = 0; k < 4; k++) begin
      x.data = l[32*k +: 32];
      x.addr = {tag, idx, 2'(k), 2'b00};
      x.last = (k == 3);
      x.beat = k;
      sb.push_back(x);
    end
  endtask

  // Call at #1 after an edge with the DUT idle; returns at #1 after accept.
  task automatic send_req(input logic [7:0] idx, input logic [19:0] tag, output int c_req);
    bif.req_valid_i = 1'b1;
    bif.req_index_i = idx;
    bif.req_tag_i   = tag;
    push_line(idx, tag);
    c_req = cyc;
    @(posedge clk); #1;
    bif.req_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_drain: observed %0d beats outstanding expected 0", tag, sb.size());
    end
  endtask

  // Beat monitor: a handshake completes at the next edge when valid&&ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stall_prev) begin
        chk("hold_valid", 32'(bif.wb_valid_o), 32'd1);
        chk("hold_data", bif.wb_data_o, held_data);
        chk("hold_addr", bif.wb_addr_o, held_addr);
        chk("hold_last", 32'(bif.wb_last_o), 32'(held_last));
      end
      if (bif.wb_valid_o && bif.wb_ready_i) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL extra_beat: observed beat 0x%08h expected none", bif.wb_data_o);
        end else begin
          e = sb.pop_front();
          chk("beat_data", bif.wb_data_o, e.data);
          chk("beat_addr", bif.wb_addr_o, e.addr);
          chk("beat_last", 32'(bif.wb_last_o), 32'(e.last));
`ifdef WB_PARITY_EN
          chk("beat_parity", 32'(bif.wb_parity_o), 32'(^e.data));
`endif
          hs_count++;
          if (e.beat == 0) first_cyc = cyc;
          if (e.beat == 3) begin
            last_cyc  = cyc;
            last_addr = bif.wb_addr_o;
          end
        end
      end
      stall_prev = bif.wb_valid_o && !bif.wb_ready_i;
      held_data  = bif.wb_data_o;
      held_addr  = bif.wb_addr_o;
      held_last  = bif.wb_last_o;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = make_line(i);
    mem[8'h3C] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    mem[8'h21] = {32'h80000001, 32'h0000000F, 32'h00000003, 32'h00000007};

    rst_n           = 1'b0;
    bif.req_valid_i = 1'b0;
    bif.req_index_i = '0;
    bif.req_tag_i   = '0;
    bif.wb_ready_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bif.req_ready_o), 32'd1);
    chk("rst_busy", 32'(bif.busy_o), 32'd0);
    chk("rst_wb_valid", 32'(bif.wb_valid_o), 32'd0);
    chk("rst_wb_last", 32'(bif.wb_last_o), 32'd0);
    chk("rst_wb_data", bif.wb_data_o, 32'd0);
    chk("rst_wb_addr", bif.wb_addr_o, 32'd0);
    chk("rst_bank_addr", 32'(bif.bank_rd_addr_o), 32'd0);
`ifdef WB_PARITY_EN
    chk("rst_parity", 32'(bif.wb_parity_o), 32'd0);
`endif
    rst_n          = 1'b1;
    bif.wb_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single line, ready always high
    send_req(8'h3C, 20'hABCDE, c0);
    chk("t1_bank_addr", 32'(bif.bank_rd_addr_o), 32'h0F0);
    chk("t1_busy", 32'(bif.busy_o), 32'd1);
    chk("t1_req_ready_low", 32'(bif.req_ready_o), 32'd0);
    wait_drain("t1");
    chk("t1_first_beat_cyc", 32'(first_cyc), 32'(c0 + 3));
    chk("t1_last_beat_cyc", 32'(last_cyc), 32'(c0 + 6));
    chk("t1_idle_ready", 32'(bif.req_ready_o), 32'd1);
    chk("t1_idle_busy", 32'(bif.busy_o), 32'd0);
    chk("t1_idle_valid", 32'(bif.wb_valid_o), 32'd0);

    // 2: backpressure for 3 cycles on beat 1
    hs_base = hs_count;
    send_req(8'h3C, 20'h12345, c0);
    while (cyc < c0 + 4) begin @(posedge clk); #1; end
    bif.wb_ready_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t2_stall_data", bif.wb_data_o, 32'h22222222);
      chk("t2_stall_addr", bif.wb_addr_o, 32'h123453C4);
    end
    bif.wb_ready_i = 1'b1;
    wait_drain("t2");
    chk("t2_handshakes", 32'(hs_count - hs_base), 32'd4);
    chk("t2_last_beat_cyc", 32'(last_cyc), 32'(c0 + 9));

    // 3: second request held from the cycle after the first accept
    send_req(8'h55, 20'h0F0F0, c0);
    bif.req_valid_i = 1'b1;
    bif.req_index_i = 8'h21;
    bif.req_tag_i   = 20'h13579;
    push_line(8'h21, 20'h13579);
    for (int n = 0; n < 50 && !bif.req_ready_o; n++) begin
      @(posedge clk); #1;
    end
    chk("t3_ready_cyc", 32'(cyc), 32'(c0 + 7));
    c1 = cyc;
    @(posedge clk); #1;
    bif.req_valid_i = 1'b0;
    wait_drain("t3");
    chk("t3_second_first_cyc", 32'(first_cyc), 32'(c1 + 3));

    // 4: asynchronous reset in the middle of SEND after beat 1
    hs_base = hs_count;
    send_req(8'h77, 20'h2468A, c0);
    while (cyc < c0 + 5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(bif.wb_valid_o), 32'd0);
    chk("t4_rst_busy", 32'(bif.busy_o), 32'd0);
    chk("t4_rst_ready", 32'(bif.req_ready_o), 32'd1);
    chk("t4_rst_last", 32'(bif.wb_last_o), 32'd0);
    chk("t4_rst_addr", bif.wb_addr_o, 32'd0);
    chk("t4_rst_data", bif.wb_data_o, 32'd0);
    chk("t4_partial_beats", 32'(hs_count - hs_base), 32'd2);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_req(8'h3C, 20'hABCDE, c0);
    wait_drain("t4");
    chk("t4_restart_first_cyc", 32'(first_cyc), 32'(c0 + 3));

    // 5: highest index and tag
    send_req(8'hFF, 20'hFFFFF, c0);
    chk("t5_bank_addr", 32'(bif.bank_rd_addr_o), 32'h3FC);
    wait_drain("t5");
    chk("t5_last_addr", last_addr, 32'hFFFFFFFC);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cache_wb_reader
`default_nettype wire
